// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle MIPS-style datapath.
// The state register resets asynchronously; the outputs are Moore-decoded, apart from MemReady-qualified strobes.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic [1:0] ALUOp,
    output logic [5:0] FunctOut,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       BranchNE,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtExe  = 4'd6,
        StRtWb   = 4'd7,
        StBranch = 4'd8,
        StIExe   = 4'd9,
        StIWb    = 4'd10,
        StJump   = 4'd11
    } state_t;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    state_t r_state;
    state_t w_next_state;
    logic   w_is_imm;

    assign w_is_imm = (Opcode == OpAddi) || (Opcode == OpAddiu) || (Opcode == OpAndi) ||
                      (Opcode == OpOri)  || (Opcode == OpXori);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = StFetch;
        ALUOp        = 2'b00;
        FunctOut     = Funct;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        MemWrite     = 1'b0;
        PCWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        Branch       = 1'b0;
        BranchNE     = 1'b0;
        ALUSrcB      = 2'b00;
        PCSrc        = 2'b00;
        IllegalOp    = 1'b0;

        case (r_state)
            StFetch: begin
                ALUSrcB      = 2'b01;
                IRWrite      = MemReady;
                PCWrite      = MemReady;
                w_next_state = MemReady ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                if ((Opcode == OpLw) || (Opcode == OpSw)) begin
                    w_next_state = StMemAdr;
                end else if (Opcode == OpRType) begin
                    w_next_state = StRtExe;
                end else if ((Opcode == OpBeq) || (Opcode == OpBne)) begin
                    w_next_state = StBranch;
                end else if (w_is_imm) begin
                    w_next_state = StIExe;
                end else if (Opcode == OpJ) begin
                    w_next_state = StJump;
                end else begin
                    IllegalOp    = 1'b1;
                    w_next_state = StFetch;
                end
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Opcode == OpLw) begin
                    w_next_state = StMemRd;
                end else if (Opcode == OpSw) begin
                    w_next_state = StMemWr;
                end else begin
                    w_next_state = StFetch;
                end
            end
            StMemRd: begin
                IorD         = 1'b1;
                w_next_state = MemReady ? StMemWb : StMemRd;
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWr: begin
                IorD         = 1'b1;
                MemWrite     = 1'b1;
                w_next_state = MemReady ? StFetch : StMemWr;
            end
            StRtExe: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                w_next_state = StRtWb;
            end
            StRtWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                Branch   = (Opcode == OpBeq);
                BranchNE = (Opcode == OpBne);
            end
            StIExe: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOp        = 2'b11;
                FunctOut     = Opcode;
                w_next_state = StIWb;
            end
            StIWb: begin
                RegWrite = 1'b1;
            end
            StJump: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: w_next_state = StFetch;
        endcase

        // The state is already FETCH while reset is high; this only masks the MemReady-driven strobes.
        if (reset) begin
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    assign State = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed plus random instructions, checked against a path-per-opcode model.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic       MemReady;
    logic [1:0] ALUOp, ALUSrcB, PCSrc;
    logic [5:0] FunctOut;
    logic       IorD, IRWrite, MemWrite, PCWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic       Branch, BranchNE, IllegalOp;
    logic [3:0] State;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
        .ALUOp(ALUOp), .FunctOut(FunctOut), .IorD(IorD), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch), .BranchNE(BranchNE),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    logic [5:0] legal_ops [11] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0d,
                                   6'h0e, 6'h23, 6'h2b};

    function automatic logic is_legal(input logic [5:0] opc);
        foreach (legal_ops[i]) if (legal_ops[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    // Control word: {ALUOp, FunctOut, IorD, IRWrite, MemWrite, PCWrite, RegDst, MemtoReg,
    //                RegWrite, ALUSrcA, Branch, BranchNE, ALUSrcB, PCSrc, IllegalOp}
    function automatic logic [22:0] expected(input int st, input logic mr,
                                             input logic [5:0] opc, input logic [5:0] fun);
        logic [1:0] aluop, srcb, pcsrc;
        logic [5:0] fo;
        logic iord, irw, mw, pcw, rd, m2r, rw, srca, br, bne, ill;
        aluop = 0; srcb = 0; pcsrc = 0; fo = fun;
        iord = 0; irw = 0; mw = 0; pcw = 0; rd = 0; m2r = 0; rw = 0; srca = 0;
        br = 0; bne = 0; ill = 0;
        case (st)
            0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; ill = !is_legal(opc); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01;
                      br = (opc == 6'h04); bne = (opc == 6'h05); end
            9:  begin srca = 1; srcb = 2'b10; aluop = 2'b11; fo = opc; end
            10: rw = 1;
            11: begin pcsrc = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {aluop, fo, iord, irw, mw, pcw, rd, m2r, rw, srca, br, bne, srcb, pcsrc, ill};
    endfunction

    function automatic logic [22:0] observed();
        return {ALUOp, FunctOut, IorD, IRWrite, MemWrite, PCWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, Branch, BranchNE, ALUSrcB, PCSrc, IllegalOp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int st, input logic mr);
        MemReady = mr;
        @(negedge clk);
        chk($sformatf("state op=%0h", Opcode), 32'(State), 32'(st));
        chk($sformatf("ctrl st=%0d op=%0h mr=%0b", st, Opcode, mr), 32'(observed()),
            32'(expected(st, mr, Opcode, Funct)));
        @(posedge clk);
        #1;
    endtask

    // Expected state path of one instruction, then drive it with the requested wait cycles.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fun,
                             input int wf, input int wm);
        int path[$];
        int w;
        Opcode = opc;
        Funct  = fun;
        path   = '{0, 1};
        if (opc == 6'h23) path = '{0, 1, 2, 3, 4};
        else if (opc == 6'h2b) path = '{0, 1, 2, 5};
        else if (opc == 6'h00) path = '{0, 1, 6, 7};
        else if (opc == 6'h04 || opc == 6'h05) path = '{0, 1, 8};
        else if (opc == 6'h02) path = '{0, 1, 11};
        else if (is_legal(opc)) path = '{0, 1, 9, 10};
        foreach (path[i]) begin
            if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
                w = (path[i] == 0) ? wf : wm;
                repeat (w) step(path[i], 1'b0);
                step(path[i], 1'b1);
            end else begin
                step(path[i], 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        Opcode   = 6'h23;
        Funct    = 6'h15;
        MemReady = 1'b1;
        #3;
        chk("reset state", 32'(State), 32'd0);
        chk("reset ctrl", 32'(observed()), 32'(expected(0, 1'b0, Opcode, Funct)));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'h23, 6'h00, 0, 0);  // LW, no waits
        run_instr(6'h2b, 6'h11, 0, 3);  // SW, three MEMWR waits
        run_instr(6'h0d, 6'h00, 0, 0);  // ORI
        run_instr(6'h05, 6'h2a, 0, 0);  // BNE
        run_instr(6'h04, 6'h2a, 0, 0);  // BEQ
        run_instr(6'h3f, 6'h00, 0, 0);  // illegal
        run_instr(6'h00, 6'h20, 2, 0);  // R-type, FETCH waits
        run_instr(6'h23, 6'h00, 1, 2);  // LW, waits in both
        run_instr(6'h02, 6'h07, 0, 0);  // J

        // Reset in the middle of a stalled store
        Opcode = 6'h2b;
        Funct  = 6'h01;
        step(0, 1'b1);
        step(1, 1'b1);
        step(2, 1'b1);
        MemReady = 1'b0;
        @(negedge clk);
        chk("memwr before reset", 32'(MemWrite), 32'd1);
        #2;
        reset    = 1'b1;
        MemReady = 1'b1;
        #1;
        chk("async reset state", 32'(State), 32'd0);
        chk("async reset memwrite", 32'(MemWrite), 32'd0);
        chk("async reset ctrl", 32'(observed()), 32'(expected(0, 1'b0, Opcode, Funct)));
        @(posedge clk);
        #1;
        chk("held reset state", 32'(State), 32'd0);
        chk("held reset ctrl", 32'(observed()), 32'(expected(0, 1'b0, Opcode, Funct)));
        reset = 1'b0;
        run_instr(6'h23, 6'h00, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [5:0] opc;
            if ($urandom_range(0, 9) < 7) opc = legal_ops[$urandom_range(0, 10)];
            else opc = 6'($urandom);
            run_instr(opc, 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have no parameters; opcode and state encodings are fixed by this document.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be held in flops clocked on the rising edge of clk.
REQ-003 Ports SHALL be, clock and reset first:
  clk  in  1  rising-edge clock.
  reset  in  1  asynchronous active-high reset.
  Opcode  in  6  instruction bits 31:26 from IR.
  Funct  in  6  instruction bits 5:0 from IR.
  MemReady  in  1  memory handshake, access completes in the cycle it is high.
  ALUOp  out  2  to ALU control unit: 00 add, 01 sub, 10 R-type, 11 I-type.
  FunctOut  out  6  to ALU control Funct input.
  IorD, IRWrite, MemWrite, PCWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, BranchNE  out  1 each  datapath strobes and selects.
  ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
  PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
  IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
  State  out  4  current state code, for debug.

Function
REQ-004 States and codes SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, RTWB 7, BRANCH 8, IEXE 9, IWB 10, JUMP 11; codes 12-15 SHALL return to FETCH on the next edge.
REQ-005 Outputs SHALL be decoded from the current state only (Moore style), except the MemReady-qualified strobes in REQ-006 and REQ-009.
REQ-006 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=MemReady; the FSM SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-007 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 100011 (LW) or 101011 (SW) -> MEMADR.
  - 000000 -> RTEXE.
  - 000100 (BEQ) or 000101 (BNE) -> BRANCH.
  - 001000, 001001, 001100, 001101, 001110 -> IEXE.
  - 000010 (J) -> JUMP.
  - any other -> FETCH with IllegalOp=1 for that DECODE cycle.
REQ-008 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to MEMRD for LW and MEMWR for SW.
REQ-009 MEMRD: IorD=1; waits for MemReady, then goes to MEMWB. MEMWR: IorD=1, MemWrite=1 held in every cycle of the state; waits for MemReady, then goes to FETCH.
REQ-010 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; goes to FETCH.
REQ-011 RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; goes to RTWB. RTWB: RegDst=1, MemtoReg=0, RegWrite=1; goes to FETCH.
REQ-012 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 for BEQ and BranchNE=1 for BNE (never both); goes to FETCH.
REQ-013 IEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=11; goes to IWB. IWB: RegDst=0, MemtoReg=0, RegWrite=1; goes to FETCH.
REQ-014 JUMP: PCSrc=10, PCWrite=1; goes to FETCH.
REQ-015 FunctOut SHALL equal Opcode in IEXE and Funct in every other state.
REQ-016 Any output not listed for a state SHALL be 0; write strobes SHALL never be 1 outside the states named above.
REQ-017 Cycle counts with MemReady held high: R-type, I-type and LW take 4 or 5 cycles as listed in REQ-018; branch and J take 3; SW takes 4. Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-018 LW SHALL take 5 cycles, R-type 4 and I-type 4.

Reset
REQ-019 Asserting reset SHALL force State=FETCH immediately, independent of clk, including mid-instruction; while reset is high, all strobes SHALL be 0, IllegalOp=0, and the selects SHALL hold their FETCH values.
REQ-020 After reset deasserts, the first rising edge SHALL be evaluated from FETCH.

Verification
REQ-021 Reset asserted during MEMWR with MemWrite=1 -> State=0 and MemWrite=0 before the next clk edge; no further write occurs.
REQ-022 Opcode=100011, MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-023 Opcode=101011, MemReady low for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-024 Opcode=001101, Funct=000000 -> in IEXE ALUOp=11 and FunctOut=001101; RegWrite=1 in IWB.
REQ-025 Opcode=000101 -> BRANCH with BranchNE=1, Branch=0, PCSrc=01; Opcode=000100 -> Branch=1, BranchNE=0.
REQ-026 Opcode=111111 -> IllegalOp=1 for exactly one cycle in DECODE, next State=0, no write strobe asserted.
